// File: rtl/nv_nvdla_cacc_csb_slave.sv
// rtl/nv_nvdla_cacc_csb_slave.sv - CACC CSB register slave with ping-pong register groups
//
// Purpose: decodes CSB requests into a small register file. The file has two
// copies (groups) of the per-layer registers. Software programs the group
// selected by the producer pointer. The datapath consumes the group selected by
// the consumer pointer. A dp2reg_done pulse retires the consumer group and
// advances the consumer pointer.
//
// Ports:
//   nvdla_core_clk / nvdla_core_rst : clock, synchronous active-high reset
//   csb2cacc_req_pvld/prdy/pd       : CSB request (prdy is always 1)
//   cacc2csb_resp_valid/pd          : one-cycle response pulse {write, error, rdata}
//   dp2reg_done                     : consumer group finished its layer
//   reg2dp_op_en/dataout_addr/misc_cfg : consumer-group configuration
//
// Optional feature: defining NVDLA_CACC_PERF_EN adds one saturating cycle
// counter per group at D_PERF_CYCLES. If it is not defined, that offset reads 0.

module nv_nvdla_cacc_csb_slave (
   input  logic        nvdla_core_clk,
   input  logic        nvdla_core_rst,
   input  logic        csb2cacc_req_pvld,
   output logic        csb2cacc_req_prdy,
   input  logic [62:0] csb2cacc_req_pd,
   output logic        cacc2csb_resp_valid,
   output logic [33:0] cacc2csb_resp_pd,
   input  logic        dp2reg_done,
   output logic        reg2dp_op_en,
   output logic [31:0] reg2dp_dataout_addr,
   output logic [15:0] reg2dp_misc_cfg
);

   logic [9:0]  req_off;
   logic [31:0] req_wdat;
   logic        req_write;
   logic        req_nposted;
   logic        unused_req_bits;

   assign req_off     = csb2cacc_req_pd[9:0];
   assign req_wdat    = csb2cacc_req_pd[53:22];
   assign req_write   = csb2cacc_req_pd[54];
   assign req_nposted = csb2cacc_req_pd[55];
   assign unused_req_bits = ^{csb2cacc_req_pd[62:56], csb2cacc_req_pd[21:10]};

   assign csb2cacc_req_prdy = 1'b1;

   logic             producer_q, producer_d;
   logic             consumer_q, consumer_d;
   logic [1:0]       op_en_q, op_en_d;
   logic [1:0][31:0] dataout_addr_q, dataout_addr_d;
   logic [1:0][15:0] misc_cfg_q, misc_cfg_d;
   logic             resp_valid_q, resp_valid_d;
   logic [33:0]      resp_pd_q, resp_pd_d;
`ifdef NVDLA_CACC_PERF_EN
   logic [1:0][31:0] perf_cnt_q, perf_cnt_d;
`endif

   logic        wr_en;
   logic        rd_err;
   logic [31:0] rd_data;
   logic [31:0] perf_rd;
   logic [1:0]  op_set;
   logic        done_hit;

   always_comb begin
      producer_d     = producer_q;
      consumer_d     = consumer_q;
      op_en_d        = op_en_q;
      dataout_addr_d = dataout_addr_q;
      misc_cfg_d     = misc_cfg_q;
`ifdef NVDLA_CACC_PERF_EN
      perf_cnt_d     = perf_cnt_q;
      perf_rd        = perf_cnt_q[producer_q];
`else
      perf_rd        = 32'h0;
`endif
      wr_en    = csb2cacc_req_pvld & req_write;
      rd_err   = 1'b0;
      rd_data  = 32'h0;
      op_set   = 2'b00;
      done_hit = dp2reg_done & op_en_q[consumer_q];

      // The read data and the error flag come from the state before this request takes effect.
      case (req_off)
         10'h000: rd_data = {15'h0, op_en_q[1], 15'h0, op_en_q[0]};
         10'h001: rd_data = {15'h0, consumer_q, 15'h0, producer_q};
         10'h002: rd_data = {31'h0, op_en_q[producer_q]};
         10'h003: rd_data = dataout_addr_q[producer_q];
         10'h004: rd_data = {16'h0, misc_cfg_q[producer_q]};
         10'h005: rd_data = perf_rd;
         default: rd_err  = 1'b1;
      endcase

      if (wr_en) begin
         case (req_off)
            10'h001: producer_d = req_wdat[0];
            10'h002: op_set[producer_q] = req_wdat[0];
            10'h003: if (!op_en_q[producer_q]) dataout_addr_d[producer_q] = req_wdat;
            10'h004: if (!op_en_q[producer_q]) misc_cfg_d[producer_q] = req_wdat[15:0];
            default: ;
         endcase
      end

      // The done clear is applied first so that a set in the same cycle wins.
      if (done_hit) begin
         op_en_d[consumer_q] = 1'b0;
         consumer_d          = ~consumer_q;
      end
      for (int g = 0; g < 2; g++) begin
         if (op_set[g]) op_en_d[g] = 1'b1;
      end

`ifdef NVDLA_CACC_PERF_EN
      for (int g = 0; g < 2; g++) begin
         if (op_set[g]) begin
            perf_cnt_d[g] = 32'h0;
         end else if ((consumer_q == 1'(g)) && op_en_q[g] && (perf_cnt_q[g] != 32'hFFFF_FFFF)) begin
            perf_cnt_d[g] = perf_cnt_q[g] + 32'h1;
         end
      end
`endif

      resp_valid_d = csb2cacc_req_pvld & (~req_write | req_nposted);
      resp_pd_d    = resp_valid_d ? {req_write, rd_err, (req_write ? 32'h0 : rd_data)} : 34'h0;
   end

   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         producer_q     <= 1'b0;
         consumer_q     <= 1'b0;
         op_en_q        <= 2'b00;
         dataout_addr_q <= '0;
         misc_cfg_q     <= '0;
         resp_valid_q   <= 1'b0;
         resp_pd_q      <= 34'h0;
`ifdef NVDLA_CACC_PERF_EN
         perf_cnt_q     <= '0;
`endif
      end else begin
         producer_q     <= producer_d;
         consumer_q     <= consumer_d;
         op_en_q        <= op_en_d;
         dataout_addr_q <= dataout_addr_d;
         misc_cfg_q     <= misc_cfg_d;
         resp_valid_q   <= resp_valid_d;
         resp_pd_q      <= resp_pd_d;
`ifdef NVDLA_CACC_PERF_EN
         perf_cnt_q     <= perf_cnt_d;
`endif
      end
   end

   // Masking with reset cancels a response that is still pending in the reset cycle.
   assign cacc2csb_resp_valid = resp_valid_q & ~nvdla_core_rst;
   assign cacc2csb_resp_pd    = resp_pd_q & {34{~nvdla_core_rst}};

   assign reg2dp_op_en        = op_en_q[consumer_q];
   assign reg2dp_dataout_addr = dataout_addr_q[consumer_q];
   assign reg2dp_misc_cfg     = misc_cfg_q[consumer_q];

endmodule

// File: tb/tb_nv_nvdla_cacc_csb_slave.sv
// tb/tb_nv_nvdla_cacc_csb_slave.sv - scoreboard testbench for nv_nvdla_cacc_csb_slave

module tb_nv_nvdla_cacc_csb_slave;

   logic        clk;
   logic        rst;
   logic        pvld;
   logic        prdy;
   logic [62:0] pd;
   logic        resp_valid;
   logic [33:0] resp_pd;
   logic        done;
   logic        op_en;
   logic [31:0] dataout_addr;
   logic [15:0] misc_cfg;

   int n_checks = 0;
   int n_fail   = 0;
   logic [33:0] exp_q[$];

   nv_nvdla_cacc_csb_slave dut (
      .nvdla_core_clk      (clk),
      .nvdla_core_rst      (rst),
      .csb2cacc_req_pvld   (pvld),
      .csb2cacc_req_prdy   (prdy),
      .csb2cacc_req_pd     (pd),
      .cacc2csb_resp_valid (resp_valid),
      .cacc2csb_resp_pd    (resp_pd),
      .dp2reg_done         (done),
      .reg2dp_op_en        (op_en),
      .reg2dp_dataout_addr (dataout_addr),
      .reg2dp_misc_cfg     (misc_cfg)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Every response the DUT produces must match the oldest expected entry.
   always @(negedge clk) begin
      if (resp_valid === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_resp: got pd=%h, expected no response", resp_pd);
         end else begin
            logic [33:0] e;
            e = exp_q.pop_front();
            if (resp_pd !== e) begin
               n_fail++;
               $display("FAIL resp_pd: got %h, expected %h", resp_pd, e);
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic csb_req(input logic [21:0] addr, input logic [31:0] wdat,
                          input logic wr, input logic np, input logic [33:0] exp);
      pd = '0;
      pd[62:56] = 7'($urandom);
      pd[21:0]  = addr;
      pd[53:22] = wdat;
      pd[54]    = wr;
      pd[55]    = np;
      pvld = 1'b1;
      if (!wr || np) exp_q.push_back(exp);
      @(posedge clk);
      #1;
      pvld = 1'b0;
      pd   = '0;
   endtask

   task automatic drain(input string name);
      idle(2);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_missing_resp: got %0d pending, expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      n_checks++;
      if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b, expected 0", resp_valid); end
      n_checks++;
      if (resp_pd !== 34'h0) begin n_fail++; $display("FAIL rst_resp_pd: got %h, expected 0", resp_pd); end
      n_checks++;
      if (prdy !== 1'b1) begin n_fail++; $display("FAIL rst_prdy: got %b, expected 1", prdy); end
      rst = 1'b0;
      idle(1);
      n_checks++;
      if ({op_en, dataout_addr, misc_cfg} !== 49'h0) begin
         n_fail++;
         $display("FAIL rst_reg2dp: got %b/%h/%h, expected 0", op_en, dataout_addr, misc_cfg);
      end
   endtask

   task automatic test_read();
      csb_req(22'h001, 32'h0, 1'b0, 1'b0, 34'h0_0000_0000);
      drain("read");
   endtask

   task automatic test_write();
      csb_req(22'h003, 32'hDEAD_BEEF, 1'b1, 1'b1, 34'h2_0000_0000);
      n_checks++;
      if (dataout_addr !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_dataout: got %h, expected deadbeef", dataout_addr); end
      csb_req(22'h004, 32'h1234_ABCD, 1'b1, 1'b0, 34'h0);
      n_checks++;
      if (misc_cfg !== 16'hABCD) begin n_fail++; $display("FAIL wr_misc: got %h, expected abcd", misc_cfg); end
      drain("write");
   endtask

   task automatic test_pingpong();
      csb_req(22'h002, 32'h1, 1'b1, 1'b0, 34'h0);
      n_checks++;
      if (op_en !== 1'b1) begin n_fail++; $display("FAIL pp_op_en_g0: got %b, expected 1", op_en); end
      csb_req(22'h003, 32'h1111_1111, 1'b1, 1'b1, 34'h2_0000_0000);
      n_checks++;
      if (dataout_addr !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL pp_locked_addr: got %h, expected deadbeef", dataout_addr); end
      csb_req(22'h001, 32'h1, 1'b1, 1'b1, 34'h2_0000_0000);
      csb_req(22'h003, 32'hCAFE_0001, 1'b1, 1'b0, 34'h0);
      csb_req(22'h004, 32'h0000_5555, 1'b1, 1'b0, 34'h0);
      csb_req(22'h002, 32'h1, 1'b1, 1'b0, 34'h0);
      csb_req(22'h000, 32'h0, 1'b0, 1'b0, 34'h0_0001_0001);
      csb_req(22'h001, 32'h0, 1'b0, 1'b0, 34'h0_0000_0001);
      n_checks++;
      if (dataout_addr !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL pp_consumer_g0_addr: got %h, expected deadbeef", dataout_addr); end
      done = 1'b1;
      idle(1);
      done = 1'b0;
      n_checks++;
      if (op_en !== 1'b1) begin n_fail++; $display("FAIL pp_op_en_g1: got %b, expected 1", op_en); end
      n_checks++;
      if (dataout_addr !== 32'hCAFE_0001 || misc_cfg !== 16'h5555) begin
         n_fail++;
         $display("FAIL pp_g1_cfg: got %h/%h, expected cafe0001/5555", dataout_addr, misc_cfg);
      end
      csb_req(22'h001, 32'h0, 1'b0, 1'b0, 34'h0_0001_0001);
      csb_req(22'h000, 32'h0, 1'b0, 1'b0, 34'h0_0001_0000);
      drain("pingpong");
   endtask

   task automatic test_done_coincide();
      done = 1'b1;
      csb_req(22'h002, 32'h1, 1'b1, 1'b1, 34'h2_0000_0000);
      done = 1'b0;
      n_checks++;
      if (op_en !== 1'b0) begin n_fail++; $display("FAIL co_op_en_g0: got %b, expected 0", op_en); end
      csb_req(22'h000, 32'h0, 1'b0, 1'b0, 34'h0_0001_0000);
      csb_req(22'h001, 32'h0, 1'b0, 1'b0, 34'h0_0000_0001);
      done = 1'b1;
      idle(1);
      done = 1'b0;
      csb_req(22'h001, 32'h0, 1'b0, 1'b0, 34'h0_0000_0001);
      drain("coincide");
   endtask

   task automatic test_unmapped();
      csb_req(22'h3FF, 32'h0, 1'b0, 1'b0, 34'h1_0000_0000);
      csb_req(22'h006, 32'hFFFF_FFFF, 1'b1, 1'b1, 34'h3_0000_0000);
      csb_req(22'h000, 32'hFFFF_FFFF, 1'b1, 1'b1, 34'h2_0000_0000);
      csb_req(22'h005, 32'h0, 1'b0, 1'b0, 34'h0_0000_0000);
      csb_req(22'h3FF001, 32'h0, 1'b0, 1'b0, 34'h0_0000_0001);
      csb_req(22'h000, 32'h0, 1'b0, 1'b0, 34'h0_0001_0000);
      drain("unmapped");
   endtask

   task automatic test_back_to_back();
      csb_req(22'h003, 32'h0, 1'b0, 1'b0, 34'h0_CAFE_0001);
      csb_req(22'h001, 32'h0, 1'b0, 1'b0, 34'h0_0000_0001);
      csb_req(22'h004, 32'h0000_7777, 1'b1, 1'b1, 34'h2_0000_0000);
      csb_req(22'h004, 32'h0, 1'b0, 1'b0, 34'h0_0000_5555);
      csb_req(22'h3FF, 32'h0, 1'b0, 1'b0, 34'h1_0000_0000);
      csb_req(22'h001, 32'h0, 1'b1, 1'b1, 34'h2_0000_0000);
      csb_req(22'h003, 32'h0, 1'b0, 1'b0, 34'h0_DEAD_BEEF);
      drain("b2b");
   endtask

   task automatic test_reset_cancel();
      pd = '0;
      pd[21:0] = 22'h001;
      pvld = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rc_cancel: got %b, expected 0", resp_valid); end
      @(posedge clk);
      #1;
      rst  = 1'b0;
      pvld = 1'b0;
      pd   = '0;
      n_checks++;
      if ({resp_valid, resp_pd, op_en, dataout_addr, misc_cfg} !== 84'h0) begin
         n_fail++;
         $display("FAIL rc_outputs: got %b/%h/%b/%h/%h, expected 0", resp_valid, resp_pd, op_en, dataout_addr, misc_cfg);
      end
      idle(2);
      csb_req(22'h001, 32'h0, 1'b0, 1'b0, 34'h0);
      csb_req(22'h000, 32'h0, 1'b0, 1'b0, 34'h0);
      drain("reset_cancel");
   endtask

   initial begin
      rst  = 1'b1;
      pvld = 1'b0;
      pd   = '0;
      done = 1'b0;
      idle(3);
      test_reset();
      test_read();
      test_write();
      test_pingpong();
      test_done_coincide();
      test_unmapped();
      test_back_to_back();
      test_reset_cancel();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
